// File: rtl/fifo_pkg.sv
// Shared definitions for the read-side FIFO consumers: default widths,
// a constant-foldable ceil(log2) helper and the packer state encoding.
package fifo_pkg;

    localparam int Data_width = 8;
    localparam int RATIO      = 4;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2_f(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } packer_state_t;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Bundle between the FIFO read port, the packer and its downstream consumer.
// With PACKER_FLUSH_EN defined the bundle also carries flush and out_keep.
interface fifo_rd_packer_if #(
    parameter int Data_width = fifo_pkg::Data_width,
    parameter int RATIO      = fifo_pkg::RATIO
);
    logic                          rd_empty;
    logic [Data_width-1:0]         rd_data;
    logic                          rd_en;
    logic                          out_valid;
    logic                          out_ready;
    logic [Data_width*RATIO-1:0]   out_data;
`ifdef PACKER_FLUSH_EN
    logic                          flush;
    logic [RATIO-1:0]              out_keep;

    modport master (
        input  rd_empty, rd_data, out_ready, flush,
        output rd_en, out_valid, out_data, out_keep
    );
    modport slave (
        output rd_empty, rd_data, out_ready, flush,
        input  rd_en, out_valid, out_data, out_keep
    );
`else
    modport master (
        input  rd_empty, rd_data, out_ready,
        output rd_en, out_valid, out_data
    );
    modport slave (
        output rd_empty, rd_data, out_ready,
        input  rd_en, out_valid, out_data
    );
`endif
endinterface

// File: rtl/out_stage_reg.sv
// Single-entry valid/ready output register. Data and valid stay stable
// while the consumer stalls; a new entry may be loaded in the drain cycle.
module out_stage_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         valid_reg;
    logic [W-1:0] data_reg;

    assign in_ready  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    // Load on accepted input, otherwise empty once the consumer takes the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (in_valid && in_ready) begin
            valid_reg <= 1'b1;
            data_reg  <= in_data;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops narrow words from the FIFO read port (one-cycle read latency) and
// packs RATIO of them, lowest lane first, into one wide valid/ready word.
// Optional feature macro: PACKER_FLUSH_EN (flush input and out_keep output).
module fifo_rd_packer #(
    parameter int Data_width = fifo_pkg::Data_width,
    parameter int RATIO      = fifo_pkg::RATIO
) (
    input  logic              clk,
    input  logic              rst,
    fifo_rd_packer_if.master  bus
);
    import fifo_pkg::*;

    localparam int CW = clog2_f(RATIO) + 1;
    localparam int OW = Data_width * RATIO;
    localparam logic [CW-1:0] FULL_CNT = CW'(RATIO);

    logic [CW-1:0]         cnt_reg, cnt_next, cnt_eff;
    logic                  inflight_reg;
    logic                  flush_pend_reg, flush_pend_next;
    logic                  flush_req;
    packer_state_t         state_reg, state_next;
    logic [Data_width-1:0] lane_next [RATIO];
    logic [OW-1:0]         word_next;
    logic                  fill_done, stage_ready, xfer, pop;

    // Lanes filled once this cycle's inflight word (if any) is captured.
    assign cnt_eff = cnt_reg + CW'(inflight_reg);

`ifdef PACKER_FLUSH_EN
    // A flush request is remembered until the partial word leaves.
    assign flush_req = bus.flush || flush_pend_reg;
`else
    assign flush_req = 1'b0;
`endif

    // Accumulator lanes: the inflight word lands in lane cnt; cleared on
    // transfer so unused lanes of a partial word read as zero.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
        logic [Data_width-1:0] acc_reg;

        assign lane_next[gi] = (inflight_reg && cnt_reg == CW'(gi)) ? bus.rd_data : acc_reg;
        assign word_next[gi*Data_width +: Data_width] = lane_next[gi];

        // Per-lane accumulator storage.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_reg <= '0;
            end else begin
                acc_reg <= xfer ? '0 : lane_next[gi];
            end
        end
    end

    // Transfer/pop decisions and next state; transfer happens in the
    // capture cycle so the last pop reaches out_valid two cycles later.
    always_comb begin
        fill_done       = 1'b0;
        xfer            = 1'b0;
        pop             = 1'b0;
        cnt_next        = cnt_eff;
        state_next      = FILL;
        flush_pend_next = 1'b0;

        fill_done = (cnt_eff == FULL_CNT) || (flush_req && cnt_eff != '0);
        xfer      = fill_done && stage_ready;
        pop       = !bus.rd_empty &&
                    (xfer || (state_reg == FILL && !fill_done && cnt_eff < FULL_CNT));

        if (xfer) begin
            cnt_next = '0;
        end
        if (fill_done && !xfer) begin
            state_next      = FULL;
            flush_pend_next = flush_req;
        end
    end

    assign bus.rd_en = pop;

    // Fill counter, read-latency tracker, flush memory and state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg        <= '0;
            inflight_reg   <= 1'b0;
            flush_pend_reg <= 1'b0;
            state_reg      <= FILL;
        end else begin
            cnt_reg        <= cnt_next;
            inflight_reg   <= pop;
            flush_pend_reg <= flush_pend_next;
            state_reg      <= state_next;
        end
    end

`ifdef PACKER_FLUSH_EN
    logic [RATIO-1:0]    keep_next;
    logic [OW+RATIO-1:0] stage_out;

    for (genvar gi = 0; gi < RATIO; gi++) begin : g_keep
        assign keep_next[gi] = (cnt_eff > CW'(gi));
    end

    out_stage_reg #(.W(OW + RATIO)) u_out (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (xfer),
        .in_ready  (stage_ready),
        .in_data   ({keep_next, word_next}),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (stage_out)
    );

    assign bus.out_data = stage_out[OW-1:0];
    assign bus.out_keep = stage_out[OW+RATIO-1:OW];
`else
    out_stage_reg #(.W(OW)) u_out (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (xfer),
        .in_ready  (stage_ready),
        .in_data   (word_next),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data)
    );
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a FIFO model feeds the read port,
// expected packed words are formed when words are written to the model,
// and a monitor compares every word the DUT hands downstream.
module tb_fifo_rd_packer;
    import fifo_pkg::*;

    localparam int DW = Data_width;
    localparam int R  = RATIO;
    localparam int OW = DW * R;

    typedef struct {
        logic [OW-1:0] data;
        logic [R-1:0]  keep;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_rd_packer_if #(.Data_width(DW), .RATIO(R)) bus ();

    fifo_rd_packer #(.Data_width(DW), .RATIO(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t          exp_q [$];
    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] pend_q [$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pops  = 0;
    int outs  = 0;
    int last_pop_cyc = 0;
    int last_out_cyc = 0;
    int empty_mode = 0;
    int ready_pct  = 100;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Pack a group of words: first word in the lowest lane.
    function automatic exp_t make_exp(input int n);
        exp_t e;
        e.data = '0;
        e.keep = '0;
        for (int i = 0; i < n; i++) begin
            e.data = e.data | (OW'(pend_q[i]) << (DW * i));
            e.keep[i] = 1'b1;
        end
        return e;
    endfunction

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        pend_q.push_back(w);
        if (pend_q.size() == R) begin
            exp_q.push_back(make_exp(R));
            pend_q.delete();
        end
    endtask

    task automatic flush_model();
        if (pend_q.size() > 0) begin
            exp_q.push_back(make_exp(pend_q.size()));
            pend_q.delete();
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #3;
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    // FIFO read-port model: a pop accepted in a cycle presents its word the
    // next cycle; otherwise rd_data carries junk the DUT must ignore.
    initial begin : driver
        bit popped;
        bit toggle;
        bit gate;
        toggle = 1'b0;
        bus.rd_empty  = 1'b1;
        bus.rd_data   = '0;
        bus.out_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
        bus.flush = 1'b0;
`endif
        forever begin
            @(negedge clk);
            popped = !rst && bus.rd_en && !bus.rd_empty;
            @(posedge clk);
            cyc++;
            #1;
            if (popped && fifo_q.size() > 0) begin
                bus.rd_data  = fifo_q.pop_front();
                pops++;
                last_pop_cyc = cyc - 1;
            end else begin
                bus.rd_data = DW'($urandom);
            end
            toggle = ~toggle;
            gate = (empty_mode == 1) ? toggle :
                   (empty_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.rd_empty  = (fifo_q.size() == 0) || gate;
            bus.out_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Output monitor: checks hold stability and pops the scoreboard on
    // every accepted word.
    initial begin : monitor
        bit            prev_hold;
        logic [OW-1:0] prev_data;
        exp_t          e;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("hold_valid", bus.out_valid, 1);
                    chk("hold_data", bus.out_data, prev_data);
                end
                if (bus.out_valid && bus.out_ready) begin
                    last_out_cyc = cyc;
                    outs++;
                    chk("out_expected_pending", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("out_data", bus.out_data, e.data);
`ifdef PACKER_FLUSH_EN
                        chk("out_keep", bus.out_keep, e.keep);
`endif
                        $display("out %0d cyc=%0d data=%0h expected=%0h", outs, cyc, bus.out_data, e.data);
                    end
                end
                prev_hold = bus.out_valid && !bus.out_ready;
                prev_data = bus.out_data;
            end
        end
    end

    initial begin : main
        int p0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rd_en", bus.rd_en, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_data", bus.out_data, 0);
        chk("reset_cnt", dut.cnt_reg, 0);
`ifdef PACKER_FLUSH_EN
        chk("reset_out_keep", bus.out_keep, 0);
`endif
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Back-to-back directed word with latency check.
        ready_pct = 100;
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
        wait_drain(50);
        chk("last_pop_to_valid", last_out_cyc - last_pop_cyc, 2);
        @(negedge clk);
        chk("valid_one_cycle", bus.out_valid, 0);

        // Backpressure: one word held, accumulator full, pops stop at 8.
        @(posedge clk);
        #2;
        ready_pct = 0;
        p0 = pops;
        for (int i = 1; i <= 12; i++) push_word(DW'(i * 8'h11));
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("bp_pops", pops - p0, 8);
        chk("bp_rd_en", bus.rd_en, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        chk("bp_out_data", bus.out_data, 32'h44332211);
        chk("bp_fifo_left", fifo_q.size(), 4);
        @(posedge clk);
        #2;
        ready_pct = 100;
        wait_drain(100);

        // Reset in the middle of a fill.
        push_word(8'h5A); push_word(8'h5B);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("midfill_cnt", dut.cnt_reg, 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        fifo_q.delete();
        pend_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midreset_out_valid", bus.out_valid, 0);
        chk("midreset_cnt", dut.cnt_reg, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        push_word(8'h61); push_word(8'h62); push_word(8'h63); push_word(8'h64);
        wait_drain(50);

        // rd_empty toggling every cycle.
        empty_mode = 1;
        for (int i = 0; i < 10 * R; i++) push_word(DW'($urandom));
        wait_drain(600);

        // Random empty and random downstream stalls.
        empty_mode = 2;
        ready_pct  = 60;
        for (int i = 0; i < 50 * R; i++) push_word(DW'($urandom));
        wait_drain(3000);
        empty_mode = 0;
        ready_pct  = 100;

`ifdef PACKER_FLUSH_EN
        // Flush with two settled lanes.
        push_word(8'hA1); push_word(8'hA2);
        repeat (6) @(posedge clk);
        #2;
        bus.flush = 1'b1;
        flush_model();
        @(posedge clk);
        #2;
        bus.flush = 1'b0;
        wait_drain(50);

        // Flush while the last word is still inflight.
        push_word(8'hB1); push_word(8'hB2); push_word(8'hB3);
        for (int n = 0; n < 50 && fifo_q.size() != 0; n++) begin
            @(posedge clk);
            #2;
        end
        bus.flush = 1'b1;
        flush_model();
        @(posedge clk);
        #2;
        bus.flush = 1'b0;
        wait_drain(50);

        // Flush with nothing accumulated has no effect.
        bus.flush = 1'b1;
        @(posedge clk);
        #2;
        bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_flush_no_out", bus.out_valid, 0);
        @(posedge clk);
        #2;
        push_word(8'hC1); push_word(8'hC2); push_word(8'hC3); push_word(8'hC4);
        wait_drain(50);
`endif

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
